// File: rtl/multi_vc_input_buffer.sv
// rtl/multi_vc_input_buffer.sv - per-VC FWFT flit FIFOs with IDLE/VA/ACTIVE packet FSM
// Define MULTI_VC_INPUT_BUFFER_ERR_EN to add sticky per-VC error_o flags.
package multi_vc_input_buffer_pkg;
  localparam int VC_SIZE   = 2;
  localparam int DATA_SIZE = 16;

  typedef enum logic [2:0] {HEAD, BODY, TAIL, HEADTAIL, EMPTY} flit_label_t;
  typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;

  typedef struct packed {
    flit_label_t          flit_label;
    logic [VC_SIZE-1:0]   vc_id;
    logic [DATA_SIZE-1:0] data;
  } flit_t;
endpackage

module multi_vc_input_buffer
  import multi_vc_input_buffer_pkg::*;
#(
  parameter int BUFFER_SIZE = 8,
  parameter int VC_NUM      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  flit_t              data_i,
  input  logic               write_i,
  input  logic [VC_NUM-1:0]  read_i,
  input  port_t              out_port_i,
  input  logic [VC_SIZE-1:0] vc_new_i,
  input  logic [VC_NUM-1:0]  vc_valid_i,
  output flit_t              data_o [VC_NUM],
  output logic [VC_NUM-1:0]  is_full_o,
  output logic [VC_NUM-1:0]  is_empty_o,
  output port_t              out_port_o [VC_NUM],
  output logic [VC_NUM-1:0]  vc_request_o
`ifdef MULTI_VC_INPUT_BUFFER_ERR_EN
  ,
  output logic [VC_NUM-1:0][2:0] error_o
`endif
);
  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_VA, S_ACTIVE} state_t;

  logic w_is_head;
  assign w_is_head = (data_i.flit_label == HEAD) || (data_i.flit_label == HEADTAIL);

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    flit_t              r_mem [BUFFER_SIZE];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    state_t             r_state;
    port_t              r_out_port;
    logic [VC_SIZE-1:0] r_vc_down;
    logic               w_wr_here;
    logic               w_label_ok;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push;
    logic               w_head_is_tail;
    flit_t              w_head;

    assign w_full     = (r_count == CNT_W'(BUFFER_SIZE));
    assign w_empty    = (r_count == '0);
    assign w_wr_here  = write_i && (data_i.vc_id == VC_SIZE'(v));
    assign w_label_ok = (r_state == S_IDLE) ? w_is_head : !w_is_head;
    assign w_pop      = read_i[v] && !w_empty && (r_state == S_ACTIVE);
    // A pop on the same edge frees a slot, so a full FIFO still takes the write.
    assign w_push     = w_wr_here && w_label_ok && (!w_full || w_pop);

    always_comb begin
      w_head       = r_mem[r_rd_ptr];
      w_head.vc_id = r_vc_down;
    end
    assign w_head_is_tail = (w_head.flit_label == TAIL) || (w_head.flit_label == HEADTAIL);

    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= data_i;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        r_state    <= S_IDLE;
        r_out_port <= LOCAL;
        r_vc_down  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push && !w_pop)      r_count <= r_count + 1'b1;
        else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        case (r_state)
          S_IDLE: if (w_push) begin
            r_state    <= S_VA;
            r_out_port <= out_port_i;
          end
          S_VA: if (vc_valid_i[v]) begin
            r_state   <= S_ACTIVE;
            r_vc_down <= vc_new_i;
          end
          S_ACTIVE: if (w_pop && w_head_is_tail) r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end

    assign data_o[v]       = w_head;
    assign is_full_o[v]    = w_full;
    assign is_empty_o[v]   = w_empty;
    assign out_port_o[v]   = r_out_port;
    assign vc_request_o[v] = (r_state == S_VA);

`ifdef MULTI_VC_INPUT_BUFFER_ERR_EN
    // Bits: {write-when-full, pop-when-empty-or-not-active, label violation}
    logic [2:0] r_err;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_err <= '0;
      else      r_err <= r_err | {w_wr_here && w_full && !w_pop,
                                  read_i[v] && (w_empty || (r_state != S_ACTIVE)),
                                  w_wr_here && !w_label_ok};
    end
    assign error_o[v] = r_err;
`endif
  end
endmodule

// File: tb/tb_multi_vc_input_buffer.sv
// tb/tb_multi_vc_input_buffer.sv - scoreboard bench for multi_vc_input_buffer
// Queue-based packet model predicts pops; a negedge monitor checks the DUT heads.
module tb_multi_vc_input_buffer;
  import multi_vc_input_buffer_pkg::*;

  localparam int BUF = 8;
  localparam int VCN = 2;
  localparam int S_IDLE = 0;
  localparam int S_VA   = 1;
  localparam int S_ACT  = 2;

  typedef struct {
    bit    valid;
    flit_t f;
  } rec_t;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  flit_t              data_i;
  logic               write_i;
  logic [VCN-1:0]     read_i;
  port_t              out_port_i;
  logic [VC_SIZE-1:0] vc_new_i;
  logic [VCN-1:0]     vc_valid_i;
  flit_t              data_o [VCN];
  logic [VCN-1:0]     is_full_o;
  logic [VCN-1:0]     is_empty_o;
  port_t              out_port_o [VCN];
  logic [VCN-1:0]     vc_request_o;
`ifdef MULTI_VC_INPUT_BUFFER_ERR_EN
  logic [VCN-1:0][2:0] error_o;
  logic [2:0]          merr [VCN];
`endif

  multi_vc_input_buffer #(.BUFFER_SIZE(BUF), .VC_NUM(VCN)) dut (
    .clk(clk),
    .rst(rst),
    .data_i(data_i),
    .write_i(write_i),
    .read_i(read_i),
    .out_port_i(out_port_i),
    .vc_new_i(vc_new_i),
    .vc_valid_i(vc_valid_i),
    .data_o(data_o),
    .is_full_o(is_full_o),
    .is_empty_o(is_empty_o),
    .out_port_o(out_port_o),
    .vc_request_o(vc_request_o)
`ifdef MULTI_VC_INPUT_BUFFER_ERR_EN
    ,
    .error_o(error_o)
`endif
  );

  always #5 clk = ~clk;

  flit_t              mq [VCN][$];
  int                 ms [VCN];
  port_t              mport [VCN];
  logic [VC_SIZE-1:0] mvc [VCN];
  rec_t               sbq [VCN][$];
  rec_t               mon_r;
  int                 tests = 0;
  int                 fails = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic flit_t mk(flit_label_t l, int vc, logic [15:0] d);
    flit_t f;
    f.flit_label = l;
    f.vc_id      = VC_SIZE'(vc);
    f.data       = d;
    return f;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < VCN; v++) begin
      mq[v].delete();
      ms[v]    = S_IDLE;
      mport[v] = LOCAL;
      mvc[v]   = '0;
`ifdef MULTI_VC_INPUT_BUFFER_ERR_EN
      merr[v]  = '0;
`endif
    end
  endtask

  task automatic model_step(bit wr, flit_t f, logic [VCN-1:0] rd, port_t p,
                            logic [VC_SIZE-1:0] vn, logic [VCN-1:0] vv);
    for (int v = 0; v < VCN; v++) begin
      bit   here, hd, ok, pop, push, tl;
      int   old;
      rec_t r;
      old  = ms[v];
      here = wr && (int'(f.vc_id) == v);
      hd   = (f.flit_label == HEAD) || (f.flit_label == HEADTAIL);
      ok   = (old == S_IDLE) ? hd : !hd;
      pop  = rd[v] && (mq[v].size() > 0) && (old == S_ACT);
      push = here && ok && ((mq[v].size() < BUF) || pop);
      if (rd[v]) begin
        r.valid = mq[v].size() > 0;
        r.f     = '0;
        if (r.valid) begin
          r.f       = mq[v][0];
          r.f.vc_id = mvc[v];
        end
        sbq[v].push_back(r);
      end
`ifdef MULTI_VC_INPUT_BUFFER_ERR_EN
      if (here && mq[v].size() == BUF && !pop) merr[v][2] = 1'b1;
      if (rd[v] && (mq[v].size() == 0 || old != S_ACT)) merr[v][1] = 1'b1;
      if (here && !ok) merr[v][0] = 1'b1;
`endif
      tl = 1'b0;
      if (pop) begin
        tl = (mq[v][0].flit_label == TAIL) || (mq[v][0].flit_label == HEADTAIL);
        void'(mq[v].pop_front());
      end
      if (push) mq[v].push_back(f);
      if (old == S_IDLE && push) begin
        ms[v]    = S_VA;
        mport[v] = p;
      end else if (old == S_VA && vv[v]) begin
        ms[v]  = S_ACT;
        mvc[v] = vn;
      end else if (old == S_ACT && tl) begin
        ms[v] = S_IDLE;
      end
    end
  endtask

  task automatic check_flags();
    for (int v = 0; v < VCN; v++) begin
      check($sformatf("flags_vc%0d", v),
            {26'd0, is_empty_o[v], is_full_o[v], vc_request_o[v], out_port_o[v]},
            {26'd0, mq[v].size() == 0, mq[v].size() == BUF, ms[v] == S_VA, mport[v]});
`ifdef MULTI_VC_INPUT_BUFFER_ERR_EN
      check($sformatf("error_vc%0d", v), {29'd0, error_o[v]}, {29'd0, merr[v]});
`endif
    end
  endtask

  task automatic idle();
    write_i    = 1'b0;
    data_i     = '0;
    read_i     = '0;
    out_port_i = LOCAL;
    vc_new_i   = '0;
    vc_valid_i = '0;
  endtask

  task automatic cycle(bit wr, flit_t f, logic [VCN-1:0] rd, port_t p,
                       logic [VC_SIZE-1:0] vn, logic [VCN-1:0] vv);
    write_i    = wr;
    data_i     = f;
    read_i     = rd;
    out_port_i = p;
    vc_new_i   = vn;
    vc_valid_i = vv;
    model_step(wr, f, rd, p, vn, vv);
    @(posedge clk);
    #1;
    check_flags();
  endtask

  always @(negedge clk) begin
    for (int v = 0; v < VCN; v++) begin
      if (rst && read_i[v]) begin
        if (sbq[v].size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_underflow_vc%0d: got read with no expectation at %0t", v, $time);
        end else begin
          mon_r = sbq[v].pop_front();
          if (mon_r.valid)
            check($sformatf("head_vc%0d", v), {11'd0, data_o[v]}, {11'd0, mon_r.f});
        end
      end
    end
  end

  initial begin
    idle();
    model_reset();
    #2;
    check_flags();
    #10 rst = 1'b1;
    @(posedge clk);
    #1;

    // single packet on VC1, allocated downstream VC0, drained in order
    cycle(1, mk(HEAD, 1, 16'h1001), '0, NORTH, '0, '0);
    cycle(1, mk(BODY, 1, 16'h1002), '0, LOCAL, '0, '0);
    cycle(1, mk(BODY, 1, 16'h1003), '0, LOCAL, '0, '0);
    cycle(1, mk(TAIL, 1, 16'h1004), '0, LOCAL, '0, '0);
    cycle(0, '0, '0, LOCAL, 2'd0, 2'b10);
    for (int i = 0; i < 4; i++) cycle(0, '0, 2'b10, LOCAL, '0, '0);

    // fill VC0, overflow, pop while in VA, then full write+pop
    cycle(1, mk(HEAD, 0, 16'h2000), '0, WEST, '0, '0);
    for (int i = 1; i < 8; i++) cycle(1, mk(BODY, 0, 16'h2000 + 16'(i)), '0, LOCAL, '0, '0);
    cycle(1, mk(BODY, 0, 16'h20ff), '0, LOCAL, '0, '0);
    cycle(0, '0, 2'b01, LOCAL, '0, '0);
    cycle(0, '0, 2'b01, LOCAL, '0, '0);
    cycle(0, '0, '0, LOCAL, 2'd2, 2'b01);
    cycle(1, mk(BODY, 0, 16'h2100), 2'b01, LOCAL, '0, '0);
    cycle(1, mk(TAIL, 0, 16'h2101), 2'b01, LOCAL, '0, '0);

    // asynchronous reset with VC1 active holding three flits
    cycle(1, mk(HEAD, 1, 16'h3001), '0, EAST, 2'd3, '0);
    cycle(1, mk(BODY, 1, 16'h3002), '0, LOCAL, 2'd3, 2'b10);
    cycle(1, mk(BODY, 1, 16'h3003), '0, LOCAL, '0, '0);
    idle();
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_flags();
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    check_flags();
    cycle(1, mk(BODY, 1, 16'h3100), '0, LOCAL, '0, '0);
    cycle(1, mk(HEAD, 1, 16'h3101), '0, SOUTH, '0, '0);

    // randomized interleaved traffic on both VCs
    for (int i = 0; i < 2500; i++) begin
      int             r;
      flit_label_t    l;
      logic [VCN-1:0] rd;
      r  = $urandom_range(0, 9);
      l  = (r < 2) ? HEAD : (r < 7) ? BODY : (r < 9) ? TAIL : HEADTAIL;
      rd = '0;
      if ($urandom_range(0, 2) != 0) rd[$urandom_range(0, VCN - 1)] = 1'b1;
      cycle($urandom_range(0, 3) != 0, mk(l, $urandom_range(0, VCN - 1), 16'($urandom)), rd,
            port_t'($urandom_range(0, 4)), VC_SIZE'($urandom), VCN'($urandom));
    end

    idle();
    @(posedge clk);
    #1;
    @(negedge clk);
    for (int v = 0; v < VCN; v++)
      check($sformatf("sb_drained_vc%0d", v), sbq[v].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
